vmem_fill_engine: RTL

- Memory-mapped rectangle-fill accelerator sitting directly upstream of the video memory (vmem).
- Merges CPU pixel stores with engine-generated pixel stores into the single vmem write port.
- The CPU programs origin, size and colour, then starts a fill. The engine writes one 3-bit RGB pixel per cycle into the {y,x}-addressed 240x240 frame buffer, with no CPU loop required.

---
 rtl/vmem_fill_engine.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/vmem_fill_engine.sv
// vmem_fill_engine
//   Rectangle-fill accelerator placed in front of the single vmem write port.
//   The CPU programs ORIGIN / SIZE / COLOR and writes CTRL.bit0 to start; the
//   engine then emits one pixel per cycle in raster order ({y,x} addressing).
//   CPU pixel stores always win the vmem port; the engine stalls for them.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   reg_we_i/addr/wdata    register write strobe, byte offset, data
//   reg_rdata_o            register read data (registered, one-cycle latency)
//   cpu_we_i/addr/wdata    CPU pixel store {y,x} / {R,G,B}
//   vmem_we/addr/wdata_o   registered vmem write port
//   busy_o                 fill in progress
//   done_o                 one-cycle pulse when a fill completes
module vmem_fill_engine #(
    parameter int LCD_W = 240,
    parameter int LCD_H = 240
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_we_i,
    input  logic [3:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [2:0]  cpu_wdata_i,
    output logic        vmem_we_o,
    output logic [15:0] vmem_addr_o,
    output logic [2:0]  vmem_wdata_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [8:0] LCD_W_L = 9'(LCD_W);
    localparam logic [8:0] LCD_H_L = 9'(LCD_H);

    state_t      r_state;
    logic [7:0]  r_x0, r_y0, r_w, r_h;
    logic [2:0]  r_color;
    logic [8:0]  r_cx, r_cy;
    logic        r_done_sticky, r_done, r_busy;
    logic        r_vmem_we;
    logic [15:0] r_vmem_addr;
    logic [2:0]  r_vmem_wdata;
    logic [31:0] r_rdata;

    state_t      w_state_nxt;
    logic [8:0]  w_cx_nxt, w_cy_nxt;
    logic        w_sticky_nxt, w_done_nxt;
    logic        w_vmem_we_nxt;
    logic [15:0] w_vmem_addr_nxt;
    logic [2:0]  w_vmem_wdata_nxt;
    logic [31:0] w_rdata_nxt;
    logic [1:0]  w_sel;
    logic        w_cfg_we, w_start, w_size_ok;
    logic [8:0]  w_x_last, w_y_last;
    logic        w_unused;

    // Pixel lies inside the visible frame; 9-bit coordinates so 240..510 never alias.
    function automatic logic pix_visible(input logic [8:0] x, input logic [8:0] y);
        return (x < LCD_W_L) && (y < LCD_H_L);
    endfunction

    assign w_sel     = reg_addr_i[3:2];
    // Configuration is frozen while a fill runs.
    assign w_cfg_we  = reg_we_i && (r_state == ST_IDLE);
    assign w_start   = w_cfg_we && (w_sel == 2'd3) && reg_wdata_i[0];
    assign w_size_ok = (r_w != 8'd0) && (r_h != 8'd0);
    assign w_x_last  = {1'b0, r_x0} + {1'b0, r_w} - 9'd1;
    assign w_y_last  = {1'b0, r_y0} + {1'b0, r_h} - 9'd1;
    assign w_unused  = ^{reg_addr_i[1:0], reg_wdata_i[31:16]};

    // Next-state, fill cursor and vmem port selection.
    always_comb begin
        w_state_nxt      = r_state;
        w_cx_nxt         = r_cx;
        w_cy_nxt         = r_cy;
        w_sticky_nxt     = r_done_sticky;
        w_done_nxt       = 1'b0;
        w_vmem_we_nxt    = cpu_we_i;
        w_vmem_addr_nxt  = cpu_addr_i;
        w_vmem_wdata_nxt = cpu_wdata_i;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_size_ok) begin
                        w_state_nxt  = ST_RUN;
                        w_cx_nxt     = {1'b0, r_x0};
                        w_cy_nxt     = {1'b0, r_y0};
                        w_sticky_nxt = 1'b0;
                    end else begin
                        // Empty rectangle completes immediately.
                        w_sticky_nxt = 1'b1;
                        w_done_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cpu_we_i) begin
                    // CPU store owns the port this cycle; cursor holds.
                    w_state_nxt = ST_RUN;
                end else begin
                    if (pix_visible(r_cx, r_cy)) begin
                        w_vmem_we_nxt    = 1'b1;
                        w_vmem_addr_nxt  = {r_cy[7:0], r_cx[7:0]};
                        w_vmem_wdata_nxt = r_color;
                    end else begin
                        // Clipped pixel still consumes its cycle.
                        w_vmem_we_nxt = 1'b0;
                    end
                    if (r_cx == w_x_last) begin
                        w_cx_nxt = {1'b0, r_x0};
                        if (r_cy == w_y_last) begin
                            w_state_nxt  = ST_IDLE;
                            w_sticky_nxt = 1'b1;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_cy_nxt = r_cy + 9'd1;
                        end
                    end else begin
                        w_cx_nxt = r_cx + 9'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Register read multiplexer.
    always_comb begin
        w_rdata_nxt = 32'd0;
        case (w_sel)
            2'd0:    w_rdata_nxt = {16'd0, r_y0, r_x0};
            2'd1:    w_rdata_nxt = {16'd0, r_h, r_w};
            2'd2:    w_rdata_nxt = {29'd0, r_color};
            2'd3:    w_rdata_nxt = {30'd0, r_done_sticky, r_busy};
            default: w_rdata_nxt = 32'd0;
        endcase
    end

    // Configuration registers, written only while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x0    <= 8'd0;
            r_y0    <= 8'd0;
            r_w     <= 8'd0;
            r_h     <= 8'd0;
            r_color <= 3'd0;
        end else if (w_cfg_we) begin
            case (w_sel)
                2'd0: begin
                    r_x0 <= reg_wdata_i[7:0];
                    r_y0 <= reg_wdata_i[15:8];
                end
                2'd1: begin
                    r_w <= reg_wdata_i[7:0];
                    r_h <= reg_wdata_i[15:8];
                end
                2'd2:    r_color <= reg_wdata_i[2:0];
                default: r_color <= r_color;
            endcase
        end
    end

    // FSM state, cursor, status flags and registered output ports.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_cx          <= 9'd0;
            r_cy          <= 9'd0;
            r_done_sticky <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_vmem_we     <= 1'b0;
            r_vmem_addr   <= 16'd0;
            r_vmem_wdata  <= 3'd0;
            r_rdata       <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cx          <= w_cx_nxt;
            r_cy          <= w_cy_nxt;
            r_done_sticky <= w_sticky_nxt;
            r_done        <= w_done_nxt;
            r_busy        <= (w_state_nxt == ST_RUN);
            r_vmem_we     <= w_vmem_we_nxt;
            r_vmem_addr   <= w_vmem_addr_nxt;
            r_vmem_wdata  <= w_vmem_wdata_nxt;
            r_rdata       <= w_rdata_nxt;
        end
    end

    assign reg_rdata_o  = r_rdata;
    assign vmem_we_o    = r_vmem_we;
    assign vmem_addr_o  = r_vmem_addr;
    assign vmem_wdata_o = r_vmem_wdata;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
